uart_tx_core: RTL and testbench
===============================

UART_TX_CORE -- requirements
Module: uart_tx_core

Interface
- REQ-001 SHALL have parameter DATA_BITS, default 8: payload bits per frame; legal range 5..9.
- REQ-002 SHALL have parameter CLKS_PER_BIT, default 16: clk cycles per line bit; legal minimum 2.
- REQ-003 SHALL have parameter PARITY_MODE, default 0: 0 none, 1 even, 2 odd.
- REQ-004 SHALL have parameter STOP_BITS, default 1: stop bits per frame; legal values 1 or 2.
- REQ-005 SHALL have port clk, input, 1: clock; all state updates on rising edge.
- REQ-006 SHALL have port reset_n, input, 1: reset; asynchronous, active-low.
- REQ-007 SHALL have port tx_data, input, DATA_BITS: frame payload.
- REQ-008 SHALL have port tx_valid, input, 1: payload offered.
- REQ-009 SHALL have port tx_ready, output, 1: block can accept a payload.
- REQ-010 SHALL have port tx_out, output, 1: serial line; idle high.
- REQ-011 SHALL have port busy, output, 1: frame in progress.
- REQ-012 SHALL have port done, output, 1: single-cycle pulse at frame end.

Function
- REQ-013 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
- REQ-014 SHALL accept a payload on a rising edge where tx_valid=1 and tx_ready=1; tx_ready SHALL equal 1 only in IDLE.
- REQ-015 SHALL latch tx_data into an internal shift register on acceptance; tx_data changes while busy SHALL have no effect.
- REQ-016 SHALL register tx_out, driving the start bit (0) starting the cycle after acceptance.
- REQ-017 SHALL hold every line bit for exactly CLKS_PER_BIT cycles, timed by a $clog2(CLKS_PER_BIT)-bit counter reset at each bit boundary.
- REQ-018 SHALL transmit data LSB first, DATA_BITS bits, tracked by a $clog2(DATA_BITS+1)-bit index.
- REQ-019 SHALL skip PARITY when PARITY_MODE=0; otherwise SHALL send one parity bit after data.
- REQ-020 SHALL compute even parity as XOR of all latched data bits, and odd parity as its inverse.
- REQ-021 SHALL drive tx_out=1 for STOP_BITS*CLKS_PER_BIT cycles in STOP.
- REQ-022 SHALL give a frame length of (1+DATA_BITS+(PARITY_MODE!=0)+STOP_BITS)*CLKS_PER_BIT cycles, measured from the first start-bit cycle.
- REQ-023 SHALL pulse done for exactly one cycle on the last cycle of the final stop bit, then return to IDLE on the following edge.
- REQ-024 SHALL hold busy=1 from the first start-bit cycle through the done cycle, and 0 otherwise.
- REQ-025 SHALL, when tx_valid=1 in the first IDLE cycle after done, accept and begin the next start bit one cycle later: at most one idle-high cycle between back-to-back frames.
- REQ-026 SHALL hold tx_out=1 in IDLE indefinitely while tx_valid=0.
- REQ-027 SHALL treat illegal parameter values as elaboration errors via assertion; no runtime behaviour defined.

Reset
- REQ-028 SHALL, while reset_n=0, force state=IDLE, tx_out=1, busy=0, done=0 and tx_ready=0, and clear the counters and shift register.
- REQ-029 SHALL set tx_ready=1 on the first rising edge after reset_n deasserts.
- REQ-030 SHALL abort any frame in progress when reset_n asserts mid-frame, driving tx_out high immediately without waiting for a clock, with no done pulse.

Verification
- REQ-031 SHALL cover the basic frame: DATA_BITS=8, CLKS_PER_BIT=4, PARITY_MODE=0, STOP_BITS=1, send 0xA5 -> tx_out sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; done pulses on cycle 40.
- REQ-032 SHALL cover even parity: PARITY_MODE=1, send 0x07 -> parity bit 1; send 0x03 -> parity bit 0; frame length 44 cycles.
- REQ-033 SHALL cover odd parity: PARITY_MODE=2, send 0x07 -> parity bit 0; send 0x00 -> parity bit 1.
- REQ-034 SHALL cover two stop bits: DATA_BITS=5, STOP_BITS=2, CLKS_PER_BIT=2, send 0x1F -> 0, 1x5, 1x2; frame 16 cycles; tx_data toggled mid-frame -> no effect on tx_out.
- REQ-035 SHALL cover back-to-back frames: tx_valid held high with 0x55 then 0xAA -> second start bit begins 2 cycles after the first done; tx_ready=0 throughout both frames.
- REQ-036 SHALL cover reset mid-frame: assert reset_n=0 during data bit 3 -> tx_out=1 and busy=0 immediately; after release, send 0x3C -> correct full frame.

Source files
------------

// File: rtl/uart_tx_core.sv
// rtl/uart_tx_core.sv - UART transmitter core: start, LSB-first data, optional parity, stop bits
// Registered serial line, one-frame-at-a-time payload handshake.
module uart_tx_core #(
   parameter int DATA_BITS    = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY_MODE  = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 tx_out,
   output logic                 busy,
   output logic                 done
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int IW = $clog2(DATA_BITS + 1);
   localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
   localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx_core: DATA_BITS must be 5..9");
   end
   if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
      $error("uart_tx_core: CLKS_PER_BIT must be at least 2");
   end
   if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity_mode
      $error("uart_tx_core: PARITY_MODE must be 0, 1 or 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_tx_core: STOP_BITS must be 1 or 2");
   end

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t                 state, state_n;
   logic [CW-1:0]          cnt, cnt_n;
   logic [IW-1:0]          idx, idx_n;
   logic [DATA_BITS-1:0]   shreg, shreg_n;
   logic                   par, par_n;
   logic                   tx_out_n;
   logic                   ready_en;
   logic                   bit_end;

   // ready_en keeps tx_ready low while in reset and releases it on the first edge after.
   assign tx_ready = (state == IDLE) && ready_en;
   assign busy     = (state != IDLE);
   assign bit_end  = (cnt == CNT_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         cnt      <= '0;
         idx      <= '0;
         shreg    <= '0;
         par      <= 1'b0;
         tx_out   <= 1'b1;
         ready_en <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         idx      <= idx_n;
         shreg    <= shreg_n;
         par      <= par_n;
         tx_out   <= tx_out_n;
         ready_en <= 1'b1;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      idx_n   = idx;
      shreg_n = shreg;
      par_n   = par;
      done    = 1'b0;

      if (state != IDLE) begin
         cnt_n = bit_end ? '0 : cnt + 1'b1;
      end

      // idx counts data bits in DATA and stop bits in STOP.
      case (state)
         IDLE: begin
            if (tx_valid && tx_ready) begin
               state_n = START;
               shreg_n = tx_data;
               par_n   = (^tx_data) ^ (PARITY_MODE == 2);
               cnt_n   = '0;
               idx_n   = '0;
            end
         end
         START: begin
            if (bit_end) state_n = DATA;
         end
         DATA: begin
            if (bit_end) begin
               shreg_n = shreg >> 1;
               if (idx == DATA_LAST) begin
                  idx_n   = '0;
                  state_n = (PARITY_MODE != 0) ? PARITY : STOP;
               end else begin
                  idx_n = idx + 1'b1;
               end
            end
         end
         PARITY: begin
            if (bit_end) state_n = STOP;
         end
         STOP: begin
            if (bit_end) begin
               if (idx == STOP_LAST) begin
                  done    = 1'b1;
                  idx_n   = '0;
                  state_n = IDLE;
               end else begin
                  idx_n = idx + 1'b1;
               end
            end
         end
         default: state_n = IDLE;
      endcase

      // The line is registered, so it follows the state being entered.
      case (state_n)
         START:   tx_out_n = 1'b0;
         DATA:    tx_out_n = shreg_n[0];
         PARITY:  tx_out_n = par_n;
         default: tx_out_n = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_core.sv
// tb/tb_uart_tx_core.sv - self-checking bench for uart_tx_core over four parameter sets
// Each frame is compared cycle by cycle against a bit list built from the frame rules.
module tb_uart_tx_core;

   localparam int NDUT = 4;
   localparam int DB  [NDUT] = '{8, 8, 8, 5};
   localparam int CPB [NDUT] = '{4, 4, 4, 2};
   localparam int PM  [NDUT] = '{0, 1, 2, 0};
   localparam int SB  [NDUT] = '{1, 1, 1, 2};

   logic             clk;
   logic             reset_n;
   logic [8:0]       tx_data [NDUT];
   logic [NDUT-1:0]  tx_valid;
   logic [NDUT-1:0]  tx_ready;
   logic [NDUT-1:0]  tx_out;
   logic [NDUT-1:0]  busy;
   logic [NDUT-1:0]  done;

   int checks   = 0;
   int failures = 0;

   uart_tx_core #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY_MODE(0), .STOP_BITS(1)) u_dut0 (
      .clk(clk), .reset_n(reset_n), .tx_data(tx_data[0][7:0]), .tx_valid(tx_valid[0]),
      .tx_ready(tx_ready[0]), .tx_out(tx_out[0]), .busy(busy[0]), .done(done[0]));
   uart_tx_core #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY_MODE(1), .STOP_BITS(1)) u_dut1 (
      .clk(clk), .reset_n(reset_n), .tx_data(tx_data[1][7:0]), .tx_valid(tx_valid[1]),
      .tx_ready(tx_ready[1]), .tx_out(tx_out[1]), .busy(busy[1]), .done(done[1]));
   uart_tx_core #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY_MODE(2), .STOP_BITS(1)) u_dut2 (
      .clk(clk), .reset_n(reset_n), .tx_data(tx_data[2][7:0]), .tx_valid(tx_valid[2]),
      .tx_ready(tx_ready[2]), .tx_out(tx_out[2]), .busy(busy[2]), .done(done[2]));
   uart_tx_core #(.DATA_BITS(5), .CLKS_PER_BIT(2), .PARITY_MODE(0), .STOP_BITS(2)) u_dut3 (
      .clk(clk), .reset_n(reset_n), .tx_data(tx_data[3][4:0]), .tx_valid(tx_valid[3]),
      .tx_ready(tx_ready[3]), .tx_out(tx_out[3]), .busy(busy[3]), .done(done[3]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // Expected line bits of one frame, one entry per line bit.
   function automatic void build_bits(input int k, input logic [8:0] d, output bit bits [$]);
      bit p;
      bits = {};
      bits.push_back(1'b0);
      p = 1'b0;
      for (int j = 0; j < DB[k]; j++) begin
         bits.push_back(d[j]);
         p ^= d[j];
      end
      if (PM[k] == 1) bits.push_back(p);
      if (PM[k] == 2) bits.push_back(~p);
      for (int j = 0; j < SB[k]; j++) bits.push_back(1'b1);
   endfunction

   // Called at a falling edge with DUT k idle. With hold=1, tx_valid stays high
   // carrying nxt so the following frame is accepted in the idle cycle after done.
   task automatic run_frame(input int k, input logic [8:0] d, input bit hold, input logic [8:0] nxt);
      bit bits [$];
      int len;
      tx_valid[k] = 1'b1;
      tx_data[k]  = d;
      build_bits(k, d, bits);
      len = bits.size() * CPB[k];
      check($sformatf("d%0d frame_len data=%0h", k, d), len,
            (1 + DB[k] + (PM[k] != 0) + SB[k]) * CPB[k]);
      for (int i = 0; i < len; i++) begin
         @(negedge clk);
         if (hold) tx_data[k] = nxt;
         else begin
            tx_valid[k] = 1'b0;
            tx_data[k]  = 9'($urandom);
         end
         check($sformatf("d%0d tx_out data=%0h c%0d", k, d, i), tx_out[k], bits[i / CPB[k]]);
         check($sformatf("d%0d busy c%0d", k, i), busy[k], 1);
         check($sformatf("d%0d done c%0d", k, i), done[k], (i == len - 1));
         check($sformatf("d%0d tx_ready c%0d", k, i), tx_ready[k], 0);
      end
      @(negedge clk);
      check($sformatf("d%0d idle tx_out", k), tx_out[k], 1);
      check($sformatf("d%0d idle busy", k), busy[k], 0);
      check($sformatf("d%0d idle done", k), done[k], 0);
      check($sformatf("d%0d idle tx_ready", k), tx_ready[k], 1);
   endtask

   initial begin
      reset_n  = 1'b0;
      tx_valid = '0;
      for (int k = 0; k < NDUT; k++) tx_data[k] = '0;
      repeat (3) @(negedge clk);
      for (int k = 0; k < NDUT; k++) begin
         check($sformatf("d%0d rst tx_out", k), tx_out[k], 1);
         check($sformatf("d%0d rst busy", k), busy[k], 0);
         check($sformatf("d%0d rst done", k), done[k], 0);
         check($sformatf("d%0d rst tx_ready", k), tx_ready[k], 0);
      end
      reset_n = 1'b1;
      @(negedge clk);
      for (int k = 0; k < NDUT; k++) check($sformatf("d%0d ready after rst", k), tx_ready[k], 1);

      run_frame(0, 9'h0A5, 1'b0, 9'h0);
      run_frame(1, 9'h007, 1'b0, 9'h0);
      run_frame(1, 9'h003, 1'b0, 9'h0);
      run_frame(2, 9'h007, 1'b0, 9'h0);
      run_frame(2, 9'h000, 1'b0, 9'h0);
      run_frame(3, 9'h01F, 1'b0, 9'h0);

      run_frame(0, 9'h055, 1'b1, 9'h0AA);
      run_frame(0, 9'h0AA, 1'b0, 9'h0);

      for (int n = 0; n < 6; n++)
         for (int k = 0; k < NDUT; k++)
            run_frame(k, 9'($urandom), 1'b0, 9'h0);

      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         for (int k = 0; k < NDUT; k++) check($sformatf("d%0d idle hold c%0d", k, i), tx_out[k], 1);
      end

      // Abort during data bit 3 (cycles 16..19 of the frame), then a clean frame.
      tx_valid[0] = 1'b1;
      tx_data[0]  = 9'h0F0;
      @(negedge clk);
      tx_valid[0] = 1'b0;
      repeat (17) @(negedge clk);
      check("d0 pre-abort busy", busy[0], 1);
      check("d0 pre-abort data bit3", tx_out[0], 0);
      #1 reset_n = 1'b0;
      #1;
      check("d0 abort tx_out", tx_out[0], 1);
      check("d0 abort busy", busy[0], 0);
      check("d0 abort done", done[0], 0);
      check("d0 abort tx_ready", tx_ready[0], 0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("d0 ready after abort", tx_ready[0], 1);
      run_frame(0, 9'h03C, 1'b0, 9'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
